// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: 2*SIZE-bit product over SIZE iterations.
// Optional early termination once the remaining multiplier bits are zero: SEQ_MUL_EARLY_TERM_EN.
module seq_shift_add_multiplier #(
  parameter int unsigned SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SIZE-1:0]     x,
  input  logic [SIZE-1:0]     y,
  output logic                busy,
  output logic                done,
  output logic [2*SIZE-1:0]   p
);

  localparam int unsigned CW = $clog2(SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [2*SIZE-1:0]   mcand;
  logic [2*SIZE-1:0]   acc;
  logic [2*SIZE-1:0]   acc_sum;
  logic [SIZE-1:0]     mplier;
  logic [SIZE-1:0]     mplier_sh;
  logic [CW-1:0]       cnt;
  logic                last;

  // One iteration's datapath result; p is loaded from acc_sum so the final add is included.
  always_comb begin
    acc_sum   = mplier[0] ? (acc + mcand) : acc;
    mplier_sh = mplier >> 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
    last      = (cnt == CW'(SIZE - 1)) || (mplier_sh == '0);
`else
    last      = (cnt == CW'(SIZE - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{SIZE{1'b0}}, x};
            mplier <= y;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + CW'(1);
          if (last) p <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier (default fixed-latency build, SIZE=4).
module tb_seq_shift_add_multiplier;

  localparam int SIZE = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [SIZE-1:0]     x, y;
  logic                busy, done;
  logic [2*SIZE-1:0]   p;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int          cyc    = 0;
  int          n_done = 0;
  logic [2*SIZE-1:0] exp_q[$];
  logic [2*SIZE-1:0] last_p;

  seq_shift_add_multiplier #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expected product.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) check("done_without_op", done, 0);
      else check("product", p, exp_q.pop_front());
    end
  end

  // Start an op, walk every cycle to the first IDLE cycle checking busy/done/p timing.
  // repulse_at=j drives start high so it is sampled at edge k+j (must be ignored).
  task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input int repulse_at, output int done_cyc);
    logic [2*SIZE-1:0] expv;
    expv = (2*SIZE)'(a) * (2*SIZE)'(b);
    done_cyc = -1;
    start = 1'b1; x = a; y = b;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0; x = SIZE'($urandom); y = SIZE'($urandom);
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("p_hold_start", p, last_p);
    for (int j = 1; j <= SIZE + 1; j++) begin
      if (repulse_at == j) begin start = 1'b1; x = '1; y = '1; end
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_walk", busy, (j <= SIZE) ? 1 : 0);
      check("done_walk", done, (j == SIZE) ? 1 : 0);
      check("p_walk", p, (j >= SIZE) ? expv : last_p);
      if (done) done_cyc = cyc;
    end
    last_p = expv;
  endtask

  initial begin
    int d1, d2, ops;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    last_p = '0; ops = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p", p, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_p", p, 0);
    end

    run_op(4'hF, 4'hF, 0, d1); ops++;
    run_op(4'd3, 4'd5, 0, d1); ops++;
    run_op(4'd0, 4'd9, 0, d2); ops++;
    check("b2b_done_spacing", d2 - d1, SIZE + 2);

    run_op(4'd7, 4'd6, 2, d1); ops++;
    run_op(4'd2, 4'd3, SIZE + 1, d1); ops++;
    run_op(4'hF, 4'd0, 0, d1); ops++;

    // Abort an in-flight multiply with an asynchronous reset.
    start = 1'b1; x = 4'd9; y = 4'd11;
    exp_q.push_back(8'd99);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_p", p, 0);
    last_p = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < SIZE + 3; i++) begin
      @(posedge clk); #1;
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
    end
    run_op(4'd9, 4'd11, 0, d1); ops++;

    for (int i = 0; i < 4; i++) begin
      run_op(SIZE'($urandom), SIZE'($urandom), 0, d1); ops++;
    end

    repeat (2) @(posedge clk); #1;
    check("done_count", n_done, ops);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
